// File: rtl/ncl_stim_pkg.sv
// Purpose: shared types and helpers for the NCL stimulus sweep generator.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ncl_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_FROM,
    ST_TO,
    ST_DONE
  } state_t;

  // Level at which rsb is considered asserted for a given gate reset polarity.
  function automatic logic rsb_on(input int sens);
    return (sens != 0);
  endfunction

  // Width of the dwell counter, wide enough to count the longer of the two dwells.
  function automatic int dwell_w(input int hold, input int rstc);
    int m;
    m = (hold > rstc) ? hold : rstc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ncl_stim_pair_cnt.sv
// Purpose: {i,j} pair counter walking every ordered (from, to) vector pair.
// Latency: registered; pair_nxt shows the value loaded on the next edge.
// Backpressure: none; advances only when inc is asserted.
module ncl_stim_pair_cnt #(
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           inc,
  input  logic           clear_j,
  output logic [2*N-1:0] pair_q,
  output logic [2*N-1:0] pair_nxt,
  output logic           last_i,
  output logic           last_j
);

  localparam logic [N-1:0] MAXV = '1;

  logic [N-1:0] i_q, i_d;
  logic [N-1:0] j_q, j_d;

  // Next pair: clear wins, then either step j or roll to the next i with j=0.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (clr) begin
      i_d = '0;
      j_d = '0;
    end else if (inc) begin
      if (clear_j) begin
        j_d = '0;
        i_d = i_q + N'(1);
      end else begin
        j_d = j_q + N'(1);
      end
    end
  end

  // Pair register.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  assign pair_q   = {i_q, j_q};
  assign pair_nxt = {i_d, j_d};
  assign last_i   = (i_q == MAXV);
  assign last_j   = (j_q == MAXV);

endmodule

// File: rtl/ncl_stim_sweep_gen.sv
// Purpose: on a req rising edge, sweep all ordered input-vector pairs onto stm_value with optional rsb pulses.
// Latency: first RST/FROM cycle follows the sampled edge; gnt pulses one cycle after the last TO cycle.
// Backpressure: none; req edges outside IDLE are dropped, not queued.
module ncl_stim_sweep_gen
  import ncl_stim_pkg::*;
#(
  parameter int INPUT_PORTS = 3,
  parameter int RESET_PORT  = 1,
  parameter int RESET_SENS  = 0,
  parameter int HOLD_CYCLES = 1,
  parameter int RST_CYCLES  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  output logic [INPUT_PORTS-1:0]   stm_value,
  output logic                     rsb,
  output logic                     gnt,
  output logic                     busy,
  output logic [2*INPUT_PORTS-1:0] pair_idx
);

  localparam int              N         = INPUT_PORTS;
  localparam logic            RSB_ON    = rsb_on(RESET_SENS);
  localparam bit              HAS_RST   = (RESET_PORT != 0);
  localparam int              CW        = dwell_w(HOLD_CYCLES, RST_CYCLES);
  localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]   RST_LAST  = CW'(RST_CYCLES - 1);
  localparam state_t          GROUP_ST  = HAS_RST ? ST_RST : ST_FROM;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            req_dly_q;
  logic [N-1:0]    stm_value_q, stm_value_d;
  logic            rsb_q, rsb_d;
  logic            gnt_q, gnt_d;
  logic            busy_q, busy_d;

  logic            pc_clr, pc_inc, pc_clear_j;
  logic [2*N-1:0]  pair_q, pair_nxt;
  logic            last_i, last_j;
  logic [N-1:0]    i_nxt, j_nxt;

  ncl_stim_pair_cnt #(.N(N)) u_pair_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (pc_clr),
    .inc      (pc_inc),
    .clear_j  (pc_clear_j),
    .pair_q   (pair_q),
    .pair_nxt (pair_nxt),
    .last_i   (last_i),
    .last_j   (last_j)
  );

  assign i_nxt = pair_nxt[2*N-1:N];
  assign j_nxt = pair_nxt[N-1:0];

  // Next state, dwell count and counter control; outputs are decoded from the next state so they register in step.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_clr     = 1'b0;
    pc_inc     = 1'b0;
    pc_clear_j = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req && !req_dly_q) begin
          pc_clr  = 1'b1;
          cnt_d   = '0;
          state_d = GROUP_ST;
        end
      end
      ST_RST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = ST_FROM;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FROM: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = ST_TO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_TO: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (!last_j) begin
            pc_inc  = 1'b1;
            state_d = ST_FROM;
          end else if (!last_i) begin
            pc_inc     = 1'b1;
            pc_clear_j = 1'b1;
            state_d    = GROUP_ST;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d == ST_RST) || (state_d == ST_FROM) || (state_d == ST_TO);
    gnt_d       = (state_d == ST_DONE);
    rsb_d       = (state_d == ST_RST) ? RSB_ON : ~RSB_ON;
    stm_value_d = '0;
    if (state_d == ST_TO) begin
      stm_value_d = j_nxt;
    end else if ((state_d == ST_RST) || (state_d == ST_FROM)) begin
      stm_value_d = i_nxt;
    end
  end

  // State, dwell counter, request edge history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_dly_q   <= 1'b1;
      stm_value_q <= '0;
      rsb_q       <= HAS_RST ? RSB_ON : ~RSB_ON;
      gnt_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_dly_q   <= req;
      stm_value_q <= stm_value_d;
      rsb_q       <= rsb_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
    end
  end

  assign stm_value = stm_value_q;
  assign rsb       = rsb_q;
  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign pair_idx  = pair_q;

endmodule

// File: tb/tb_ncl_stim_sweep_gen.sv
// Purpose: directed bench for ncl_stim_sweep_gen across four parameter sets.
// Latency: samples 1 time unit after each rising clock edge.
// Backpressure: n/a.
module tb_ncl_stim_sweep_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic req0, req1, req2, req3;

  logic [2:0] stm0; logic rsb0, gnt0, busy0; logic [5:0] pair0;
  logic [1:0] stm1; logic rsb1, gnt1, busy1; logic [3:0] pair1;
  logic [2:0] stm2; logic rsb2, gnt2, busy2; logic [5:0] pair2;
  logic [0:0] stm3; logic rsb3, gnt3, busy3; logic [1:0] pair3;

  int total = 0;
  int bad   = 0;

  // Defaults: N=3, reset pulses active-low, hold 1, reset 2.
  ncl_stim_sweep_gen u0 (
    .clk(clk), .rst(rst), .req(req0), .stm_value(stm0), .rsb(rsb0),
    .gnt(gnt0), .busy(busy0), .pair_idx(pair0)
  );

  ncl_stim_sweep_gen #(.INPUT_PORTS(2), .RESET_PORT(0)) u1 (
    .clk(clk), .rst(rst), .req(req1), .stm_value(stm1), .rsb(rsb1),
    .gnt(gnt1), .busy(busy1), .pair_idx(pair1)
  );

  ncl_stim_sweep_gen #(.INPUT_PORTS(3), .RESET_SENS(1), .RST_CYCLES(3)) u2 (
    .clk(clk), .rst(rst), .req(req2), .stm_value(stm2), .rsb(rsb2),
    .gnt(gnt2), .busy(busy2), .pair_idx(pair2)
  );

  ncl_stim_sweep_gen #(.INPUT_PORTS(1), .RESET_PORT(0), .HOLD_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .req(req3), .stm_value(stm3), .rsb(rsb3),
    .gnt(gnt3), .busy(busy3), .pair_idx(pair3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-written stm_value sequence for N=2, no reset pulses, hold 1.
  int exp2 [32] = '{0,0, 0,1, 0,2, 0,3, 1,0, 1,1, 1,2, 1,3,
                    2,0, 2,1, 2,2, 2,3, 3,0, 3,1, 3,2, 3,3};
  // Hand-written stm_value sequence for N=1, hold 3 (first cycle is the MSB).
  logic [23:0] seq6 = 24'b000000000111111000111111;

  initial begin
    int n, gcount, bcount;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; req2 = 1'b0; req3 = 1'b0;
    repeat (10) tick();

    // Reset values while rst is high.
    chk("rst_u0", {busy0, gnt0, rsb0, stm0, pair0}, 32'h0);
    chk("rst_u1_rsb", rsb1, 1'b1);
    chk("rst_u2_rsb", rsb2, 1'b1);
    chk("rst_u3", {busy3, gnt3, rsb3, stm3, pair3}, {1'b0, 1'b0, 1'b1, 1'b0, 2'b00});
    rst = 1'b0;
    tick();
    chk("idle_u0_rsb", rsb0, 1'b1);
    chk("idle_u2_rsb", rsb2, 1'b0);

    // Test 1: default full sweep.
    req0 = 1'b1; tick(); req0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < 2; r++) begin
        chk("t1_rst", {busy0, rsb0, gnt0, stm0, pair0}, {1'b1, 1'b0, 1'b0, 3'(i), 3'(i), 3'd0});
        tick();
      end
      for (int j = 0; j < 8; j++) begin
        chk("t1_from", {busy0, rsb0, gnt0, stm0, pair0}, {1'b1, 1'b1, 1'b0, 3'(i), 3'(i), 3'(j)});
        tick();
        chk("t1_to", {busy0, rsb0, gnt0, stm0, pair0}, {1'b1, 1'b1, 1'b0, 3'(j), 3'(i), 3'(j)});
        tick();
      end
    end
    chk("t1_done", {busy0, rsb0, gnt0, stm0}, {1'b0, 1'b1, 1'b1, 3'd0});
    tick();
    chk("t1_after", {busy0, gnt0}, 2'b00);

    // Test 2: N=2 without reset pulses.
    req1 = 1'b1; tick(); req1 = 1'b0;
    for (int k = 0; k < 32; k++) begin
      chk("t2_cyc", {busy1, rsb1, gnt1, stm1, pair1}, {1'b1, 1'b1, 1'b0, 2'(exp2[k]), 4'(k / 2)});
      tick();
    end
    chk("t2_done", {busy1, rsb1, gnt1, stm1}, {1'b0, 1'b1, 1'b1, 2'd0});
    tick();
    chk("t2_after", gnt1, 1'b0);

    // Test 3: active-high reset pulses of 3 cycles before each group.
    req2 = 1'b1; tick(); req2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < 3; r++) begin
        chk("t3_rst", {busy2, rsb2, stm2, pair2}, {1'b1, 1'b1, 3'(i), 3'(i), 3'd0});
        tick();
      end
      for (int k = 0; k < 16; k++) begin
        chk("t3_hold", {busy2, rsb2}, 2'b10);
        tick();
      end
    end
    chk("t3_done", {gnt2, busy2, rsb2}, 3'b100);

    // Test 4: rst during busy cycle 50 discards the sweep.
    tick();
    req0 = 1'b1; tick(); req0 = 1'b0;
    repeat (49) tick();
    chk("t4_pair50", {busy0, stm0, pair0}, {1'b1, 3'd5, 6'h15});
    rst = 1'b1; tick();
    chk("t4_in_rst", {busy0, gnt0, rsb0, stm0, pair0}, 32'h0);
    rst = 1'b0; tick();
    gcount = 0;
    for (int k = 0; k < 200; k++) begin
      if (gnt0 || busy0) gcount++;
      tick();
    end
    chk("t4_no_gnt", gcount, 0);
    req0 = 1'b1; tick(); req0 = 1'b0;
    chk("t4_restart", {busy0, rsb0, stm0, pair0}, {1'b1, 1'b0, 3'd0, 6'h00});
    n = 0;
    while (!gnt0 && n < 400) begin tick(); n++; end
    chk("t4_restart_gnt", gnt0, 1'b1);
    tick();

    // Test 5: req high through reset release, toggles while busy and in DONE.
    rst = 1'b1; req0 = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("t5_no_start", busy0, 1'b0);
    req0 = 1'b0; tick(); req0 = 1'b1; tick();
    chk("t5_start", busy0, 1'b1);
    gcount = 0; bcount = 0;
    for (int c = 1; c <= 144; c++) begin
      if (gnt0) gcount++;
      if (busy0) bcount++;
      if (c >= 10 && c <= 30) req0 = c[0];
      if (c == 144) req0 = 1'b0;
      tick();
    end
    chk("t5_done_gnt", gnt0, 1'b1);
    if (gnt0) gcount++;
    req0 = 1'b1; tick();
    chk("t5_done_edge", busy0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (gnt0) gcount++;
      if (busy0) bcount++;
      tick();
    end
    chk("t5_one_gnt", gcount, 1);
    chk("t5_busy_len", bcount, 144);
    req0 = 1'b0; tick(); req0 = 1'b1; tick();
    chk("t5_second_start", busy0, 1'b1);
    bcount = 0; n = 0;
    while (!gnt0 && n < 400) begin
      if (busy0) bcount++;
      tick(); n++;
    end
    chk("t5_second_gnt", gnt0, 1'b1);
    chk("t5_second_len", bcount, 144);
    req0 = 1'b0;
    tick();

    // Test 6: N=1, hold 3 cycles per vector.
    req3 = 1'b1; tick(); req3 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      chk("t6_cyc", {busy3, rsb3, gnt3, stm3, pair3}, {1'b1, 1'b1, 1'b0, seq6[23 - k], 2'(k / 6)});
      tick();
    end
    chk("t6_done", {busy3, gnt3, stm3}, 3'b010);
    tick();
    chk("t6_after", {busy3, gnt3}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
